// File: rtl/instr_decoder_pkg.sv
// Shared constants and types for the instruction framing receiver.
// INSTR_HEAD / INSTR_TAIL must match the values the link encoder emits.
package instr_decoder_pkg;

    localparam logic [31:0] INSTR_HEAD = 32'hC0DE_CAFE;
    localparam logic [31:0] INSTR_TAIL = 32'hE0F1_7A11;

    // Frame position: waiting for HEAD, then INSTR, TAIL and CHECK words in turn.
    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_INSTR = 2'd1,
        ST_TAIL  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

endpackage

// File: rtl/instr_decoder_sat_counter.sv
// Saturating up-counter used for the frame statistics.
// Holds at all-ones instead of wrapping so a long-running link never under-reports.
module instr_decoder_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_reg;

    // Count one per inc, stop at all-ones; clear wins over inc.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/instr_decoder.sv
// Receive side of the instruction framing link.
// Hunts for HEAD, captures the instruction, verifies TAIL and the check word
// ~(HEAD+INSTR+TAIL), and hands good instructions to a one-entry valid/ready buffer.
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rstn,
    input  logic                  in_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  err_tail,
    output logic                  err_check,
    output logic                  err_timeout,
    output logic                  err_ovf,
    output logic [CNT_WIDTH-1:0]  ok_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [DATA_WIDTH-1:0] HEAD_W  = DATA_WIDTH'(INSTR_HEAD);
    localparam logic [DATA_WIDTH-1:0] TAIL_W  = DATA_WIDTH'(INSTR_TAIL);
    // Gap counter only needs to reach TIMEOUT; it saturates there.
    localparam int                    GAP_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GAP_W-1:0]      GAP_LIM = GAP_W'(TIMEOUT);

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] sum_reg;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic [GAP_W-1:0]      gap_reg;

    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  err_tail_reg;
    logic                  err_check_reg;
    logic                  err_timeout_reg;
    logic                  err_ovf_reg;

    logic head_hit;
    logic tail_hit;
    logic check_hit;
    logic tail_bad;
    logic check_bad;
    logic frame_good;
    logic deliver;
    logic ovf;
    logic timeout_hit;
    logic err_any;

    // Per-cycle frame events; these feed both the registered pulses and the counters
    // so a pulse and its counter increment land on the same edge.
    always_comb begin
        head_hit    = (in_data == HEAD_W);
        tail_hit    = (in_data == TAIL_W);
        check_hit   = (in_data == ~sum_reg);
        tail_bad    = in_en && (state_reg == ST_TAIL) && !tail_hit;
        check_bad   = in_en && (state_reg == ST_CHECK) && !check_hit;
        frame_good  = in_en && (state_reg == ST_CHECK) && check_hit;
        // The buffer can take a new frame if it is empty or being drained this cycle.
        deliver     = frame_good && (!out_valid_reg || out_ready);
        ovf         = frame_good && !deliver;
        timeout_hit = (TIMEOUT != 0) && !in_en && (state_reg != ST_HUNT) && (gap_reg == GAP_LIM);
        err_any     = tail_bad || check_bad || ovf || timeout_hit;
    end

    // Frame FSM: only in_en cycles advance it; idle cycles feed the gap counter.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_reg       <= ST_HUNT;
            sum_reg         <= '0;
            instr_reg       <= '0;
            gap_reg         <= '0;
            err_tail_reg    <= 1'b0;
            err_check_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_ovf_reg     <= 1'b0;
        end else begin
            err_tail_reg    <= tail_bad;
            err_check_reg   <= check_bad;
            err_timeout_reg <= timeout_hit;
            err_ovf_reg     <= ovf;

            if (in_en) begin
                gap_reg <= '0;
            end else if (gap_reg != GAP_LIM) begin
                gap_reg <= gap_reg + 1'b1;
            end

            if (in_en) begin
                unique case (state_reg)
                    ST_HUNT: begin
                        if (head_hit) begin
                            sum_reg   <= HEAD_W;
                            state_reg <= ST_INSTR;
                        end
                    end
                    ST_INSTR: begin
                        instr_reg <= in_data;
                        sum_reg   <= sum_reg + in_data;
                        state_reg <= ST_TAIL;
                    end
                    ST_TAIL: begin
                        if (tail_hit) begin
                            sum_reg   <= sum_reg + TAIL_W;
                            state_reg <= ST_CHECK;
                        end else if (head_hit) begin
                            // A fresh HEAD where TAIL was expected starts a new frame at once.
                            sum_reg   <= HEAD_W;
                            state_reg <= ST_INSTR;
                        end else begin
                            state_reg <= ST_HUNT;
                        end
                    end
                    ST_CHECK: begin
                        state_reg <= ST_HUNT;
                    end
                    default: begin
                        state_reg <= ST_HUNT;
                    end
                endcase
            end else if (timeout_hit) begin
                state_reg <= ST_HUNT;
            end
        end
    end

    // One-entry output buffer: load on delivery, clear when the consumer takes it.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (deliver) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= instr_reg;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    instr_decoder_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ok_cnt (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .inc      (deliver),
        .clear    (1'b0),
        .count    (ok_cnt)
    );

    instr_decoder_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .inc      (err_any),
        .clear    (1'b0),
        .count    (err_cnt)
    );

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign err_tail    = err_tail_reg;
    assign err_check   = err_check_reg;
    assign err_timeout = err_timeout_reg;
    assign err_ovf     = err_ovf_reg;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: directed frame scenarios plus a randomized stream,
// all checked against a frame-level reference model kept here.
module tb_instr_decoder;
    import instr_decoder_pkg::*;

    localparam int TMO = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        in_en = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        out_valid, err_tail, err_check, err_timeout, err_ovf;
    logic [31:0] out_data;
    logic [15:0] ok_cnt, err_cnt;

    logic        s_valid, s_tail, s_check, s_timeout, s_ovf;
    logic [31:0] s_data;
    logic [1:0]  s_ok, s_err;

    int total = 0;
    int bad = 0;

    always #5 sys_clk = ~sys_clk;

    instr_decoder #(.DATA_WIDTH(32), .TIMEOUT(TMO), .CNT_WIDTH(16)) u_dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .in_en(in_en), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_tail(err_tail), .err_check(err_check), .err_timeout(err_timeout),
        .err_ovf(err_ovf), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    instr_decoder #(.DATA_WIDTH(32), .TIMEOUT(TMO), .CNT_WIDTH(2)) u_sat (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .in_en(in_en), .in_data(in_data),
        .out_valid(s_valid), .out_ready(out_ready), .out_data(s_data),
        .err_tail(s_tail), .err_check(s_check), .err_timeout(s_timeout),
        .err_ovf(s_ovf), .ok_cnt(s_ok), .err_cnt(s_err)
    );

    // ---------------- reference model (frame level) ----------------
    logic [31:0] fq[$];          // words of the frame collected so far
    int          gap;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_et, m_ec, m_eto, m_eo;
    int          okn, errn;

    function automatic logic [31:0] chk(input logic [31:0] x);
        logic [31:0] s;
        s = INSTR_HEAD + x + INSTR_TAIL;
        return ~s;
    endfunction

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic model_reset();
        fq.delete();
        gap = 0; m_valid = 0; m_data = '0;
        m_et = 0; m_ec = 0; m_eto = 0; m_eo = 0;
        okn = 0; errn = 0;
    endtask

    task automatic model_step(input bit en, input logic [31:0] d, input bit rdy);
        bit          pop, good;
        logic [31:0] inst, sum;
        pop = m_valid && rdy;
        good = 0; inst = '0;
        m_et = 0; m_ec = 0; m_eto = 0; m_eo = 0;
        if (en) begin
            gap = 0;
            if (fq.size() == 0) begin
                if (d == INSTR_HEAD) fq.push_back(d);
            end else if (fq.size() == 1) begin
                fq.push_back(d);
            end else if (fq.size() == 2) begin
                if (d == INSTR_TAIL) fq.push_back(d);
                else begin
                    m_et = 1;
                    fq.delete();
                    if (d == INSTR_HEAD) fq.push_back(d);
                end
            end else begin
                sum = fq[0] + fq[1] + fq[2];
                if (d == ~sum) begin good = 1; inst = fq[1]; end
                else m_ec = 1;
                fq.delete();
            end
        end else begin
            if (fq.size() > 0 && TMO > 0 && gap == TMO) begin
                m_eto = 1;
                fq.delete();
            end
            if (gap < TMO) gap++;
        end
        if (good) begin
            if (!m_valid || rdy) begin m_data = inst; m_valid = 1; okn++; end
            else m_eo = 1;
        end else if (pop) begin
            m_valid = 0;
        end
        if (m_et || m_ec || m_eto || m_eo) errn++;
    endtask

    // Drive one cycle (inputs change on the falling edge), step the model,
    // and return on the next falling edge with outputs settled.
    task automatic tick(input bit en, input logic [31:0] d, input bit rdy);
        in_en = en; in_data = d; out_ready = rdy;
        model_step(en, d, rdy);
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [31:0] x, input bit rdy);
        tick(1, INSTR_HEAD, rdy);
        tick(1, x, rdy);
        tick(1, INSTR_TAIL, rdy);
        tick(1, chk(x), rdy);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rstn = 0; in_en = 0; out_ready = 0;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rstn = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rstn = 0;
        #2;
        total++;
        if ({out_valid, out_data, err_tail, err_check, err_timeout, err_ovf, ok_cnt, err_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%0b data=%h ok=%0d err=%0d required all 0",
                     out_valid, out_data, ok_cnt, err_cnt);
        end
        model_reset();
        @(negedge sys_clk);
        sys_rstn = 1;
        $display("test_reset: outputs checked while in reset");
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1, INSTR_HEAD, 1);
        tick(1, 32'h1234_5678, 1);
        tick(1, INSTR_TAIL, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_early_valid got=%0b required=0", out_valid);
        end
        tick(1, chk(32'h1234_5678), 1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || ok_cnt !== 16'd1) begin
            bad++; $display("FAIL b2b_first got valid=%0b data=%h ok=%0d required 1/12345678/1",
                            out_valid, out_data, ok_cnt);
        end
        send_frame(32'h0BAD_F00D, 1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h0BAD_F00D || ok_cnt !== 16'd2 || err_cnt !== 16'd0) begin
            bad++; $display("FAIL b2b_second got valid=%0b data=%h ok=%0d err=%0d required 1/0badf00d/2/0",
                            out_valid, out_data, ok_cnt, err_cnt);
        end
        $display("test_back_to_back: frames 12345678, 0badf00d");
    endtask

    task automatic test_check_error();
        do_reset();
        tick(1, 32'h0000_DEAD, 1);
        tick(1, INSTR_HEAD, 1);
        tick(1, 32'h1, 1);
        tick(1, INSTR_TAIL, 1);
        tick(1, 32'hFFFF_FFFF, 1);
        total++;
        if (err_check !== 1'b1 || out_valid !== 1'b0 || err_cnt !== 16'd1) begin
            bad++; $display("FAIL check_err got chk=%0b valid=%0b err=%0d required 1/0/1",
                            err_check, out_valid, err_cnt);
        end
        tick(0, 32'h0, 1);
        total++;
        if (err_check !== 1'b0) begin
            bad++; $display("FAIL check_err_pulse got=%0b required=0", err_check);
        end
        send_frame(32'hCAFE_0001, 1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hCAFE_0001 || ok_cnt !== 16'd1) begin
            bad++; $display("FAIL check_recover got valid=%0b data=%h ok=%0d required 1/cafe0001/1",
                            out_valid, out_data, ok_cnt);
        end
        $display("test_check_error: bad check then frame cafe0001");
    endtask

    task automatic test_resync();
        do_reset();
        tick(1, INSTR_HEAD, 1);
        tick(1, 32'h5, 1);
        tick(1, INSTR_HEAD, 1);
        total++;
        if (err_tail !== 1'b1) begin
            bad++; $display("FAIL resync_tail got=%0b required=1", err_tail);
        end
        tick(1, 32'h6, 1);
        tick(1, INSTR_TAIL, 1);
        tick(1, chk(32'h6), 1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h6 || ok_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            bad++; $display("FAIL resync_frame got valid=%0b data=%h ok=%0d err=%0d required 1/6/1/1",
                            out_valid, out_data, ok_cnt, err_cnt);
        end
        $display("test_resync: frame 6 after tail error");
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        do_reset();
        tick(1, INSTR_HEAD, 1);
        tick(1, 32'h7, 1);
        for (int i = 0; i < TMO; i++) begin
            tick(0, $urandom, 1);
            if (err_timeout !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL timeout_early got=%0d early pulses required=0", early);
        end
        tick(0, 32'h0, 1);
        total++;
        if (err_timeout !== 1'b1 || err_cnt !== 16'd1) begin
            bad++; $display("FAIL timeout_fire got to=%0b err=%0d required 1/1", err_timeout, err_cnt);
        end
        tick(1, INSTR_TAIL, 1);
        tick(1, chk(32'h7), 1);
        total++;
        if (out_valid !== 1'b0 || ok_cnt !== 16'd0 || err_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_after got valid=%0b ok=%0d to=%0b required 0/0/0",
                            out_valid, ok_cnt, err_timeout);
        end
        $display("test_timeout: gap of %0d idle cycles", TMO + 1);
    endtask

    task automatic test_overflow();
        do_reset();
        send_frame(32'hA, 0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin
            bad++; $display("FAIL ovf_first got valid=%0b data=%h required 1/a", out_valid, out_data);
        end
        send_frame(32'hB, 0);
        total++;
        if (err_ovf !== 1'b1 || out_data !== 32'hA || ok_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            bad++; $display("FAIL ovf_drop got ovf=%0b data=%h ok=%0d err=%0d required 1/a/1/1",
                            err_ovf, out_data, ok_cnt, err_cnt);
        end
        tick(0, 32'h0, 1);
        total++;
        if (out_valid !== 1'b0 || err_ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_release got valid=%0b ovf=%0b required 0/0", out_valid, err_ovf);
        end
        $display("test_overflow: a held, b dropped");
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(32'h33, 0);
        tick(1, INSTR_HEAD, 0);
        tick(1, 32'h9, 0);
        sys_rstn = 0;
        #1;
        total++;
        if ({out_valid, out_data, err_tail, err_check, err_timeout, err_ovf, ok_cnt, err_cnt} !== '0 ||
            {s_valid, s_ok} !== '0) begin
            bad++; $display("FAIL mid_reset got valid=%0b data=%h ok=%0d required all 0",
                            out_valid, out_data, ok_cnt);
        end
        model_reset();
        @(negedge sys_clk);
        sys_rstn = 1;
        send_frame(32'h9, 1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h9 || ok_cnt !== 16'd1) begin
            bad++; $display("FAIL mid_reset_after got valid=%0b data=%h ok=%0d required 1/9/1",
                            out_valid, out_data, ok_cnt);
        end
        $display("test_reset_mid: frame 9 after reset");
    endtask

    task automatic test_random();
        logic [31:0] gq[$];
        logic [31:0] x, tl, ck;
        logic [68:0] got_b, exp_b;
        logic [37:0] got_s, exp_s;
        int r, shown;
        bit en, rdy;
        shown = 0;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (gq.size() == 0) begin
                r = $urandom_range(0, 9);
                x = $urandom;
                tl = INSTR_TAIL;
                ck = chk(x);
                if (r == 0) gq.push_back($urandom);
                if (r == 1) tl = $urandom;
                if (r == 2) tl = INSTR_HEAD;
                if (r == 3) ck = ck ^ (32'h1 << $urandom_range(0, 31));
                gq.push_back(INSTR_HEAD);
                gq.push_back(x);
                gq.push_back(tl);
                gq.push_back(ck);
            end
            rdy = ($urandom_range(0, 2) != 0);
            en = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 149) == 0) begin
                for (int k = 0; k < TMO + 2; k++) tick(0, $urandom, rdy);
            end
            if (en) tick(1, gq.pop_front(), rdy);
            else    tick(0, $urandom, rdy);
            got_b = {out_valid, out_data, err_tail, err_check, err_timeout, err_ovf, ok_cnt, err_cnt};
            exp_b = {m_valid, m_data, m_et, m_ec, m_eto, m_eo, sat16(okn), sat16(errn)};
            got_s = {s_valid, s_data, s_ok, s_err};
            exp_s = {m_valid, m_data, sat2(okn), sat2(errn)};
            total++;
            if (got_b !== exp_b) begin
                bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_main cyc=%0d got=%h required=%h", cyc, got_b, exp_b);
                end
            end
            total++;
            if (got_s !== exp_s) begin
                bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_sat cyc=%0d got=%h required=%h", cyc, got_s, exp_s);
                end
            end
        end
        $display("test_random: delivered=%0d errors=%0d", okn, errn);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_check_error();
        test_resync();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
